io_port_ctrl: RTL

- Controller for the 16-bit processor's input and output ports (read_in / write_out).
- Sits between the core and the outside world (bench or host). Sequences input words into the core and buffers core output words through a valid/ready handshake.
- Stalls the core when an input is requested and none is available, or when an output is issued and the output buffer is full.
- Counts stall cycles for bring-up diagnostics.

---
 rtl/io_ctrl_pkg.sv | 15 +
 rtl/io_out_fifo.sv | 73 +++++++
 rtl/io_port_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared defaults and the debug status encoding for the processor I/O port controller.
package io_ctrl_pkg;

    localparam int unsigned WORD_W_DEF    = 16;
    localparam int unsigned OUT_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IN   = 2'd1,
        WAIT_OUT  = 2'd2,
        WAIT_BOTH = 2'd3
    } io_state_e;

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous output FIFO with occupancy count; DEPTH must be a power of two (>= 2).
module io_out_fifo
    import io_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W_DEF,
    parameter int unsigned DEPTH = OUT_DEPTH_DEF,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[head_q];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) begin
            tail_d = tail_q + PW'(1);
        end
        if (do_pop) begin
            head_d = head_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= data_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// Input holding register, output FIFO, core stall generation, stall counter and debug status
// for the 16-bit processor's read_in / write_out ports.
module io_port_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              core_in_req,
    output logic [WORD_W-1:0] core_in_data,
    input  logic              core_out_req,
    input  logic [WORD_W-1:0] core_out_data,
    output logic              core_stall,
    input  logic [WORD_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [WORD_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    logic              in_full_q, in_full_d;
    logic [WORD_W-1:0] in_buf_q, in_buf_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    io_state_e         io_state_q;

    logic              stall_in, stall_out;
    logic              out_push, out_pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     out_count;

    assign ext_in_ready  = rst & ~in_full_q;
    assign core_in_data  = in_buf_q;
    assign stall_count   = stall_cnt_q;
    assign ext_out_valid = (out_count != '0);

    assign stall_in   = core_in_req & ~in_full_q;
    assign stall_out  = core_out_req & fifo_full;
    assign core_stall = stall_in | stall_out;

    // Any stall blocks both the input consume and the output push together.
    assign out_push = core_out_req & ~core_stall;
    assign out_pop  = ext_out_valid & ext_out_ready;

    io_out_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (rst),
        .push_i  (out_push),
        .data_i  (core_out_data),
        .pop_i   (out_pop),
        .data_o  (ext_out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (out_count)
    );

    always_comb begin
        in_full_d   = in_full_q;
        in_buf_d    = in_buf_q;
        stall_cnt_d = stall_cnt_q;
        if (core_in_req && !core_stall) begin
            in_full_d = 1'b0;
        end else if (ext_in_valid && ext_in_ready) begin
            in_full_d = 1'b1;
            in_buf_d  = ext_in_data;
        end
        if (core_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            in_full_q   <= 1'b0;
            in_buf_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            in_full_q   <= in_full_d;
            in_buf_q    <= in_buf_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            io_state_q <= RUN;
        end else begin
            case ({stall_in, stall_out})
                2'b00:   io_state_q <= RUN;
                2'b10:   io_state_q <= WAIT_IN;
                2'b01:   io_state_q <= WAIT_OUT;
                default: io_state_q <= WAIT_BOTH;
            endcase
        end
    end

    a_fifo_count_sane: assert property (@(posedge clock) disable iff (!rst)
        (out_count <= CW'(OUT_DEPTH)) && (fifo_empty == (out_count == '0)));

endmodule
